// File: rtl/shifter_pkg.sv
// Shared definitions for the 32-bit shifter path.
//   DEF_WIDTH / DEF_AMT_W : default data and amount widths
//   state_t               : serial un-rotator FSM encoding
//   DIR_RIGHT / DIR_LEFT  : rotation direction flags, same meaning as the
//                           combinational multifunction shifter's lr input
package shifter_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_AMT_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

   // Undoing a rotation means rotating the other way.
   function automatic logic inverse_dir(input logic dir);
      return (dir == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
   endfunction

endpackage

// File: rtl/rot1_32.sv
// Combinational single-bit rotator.
//   d   : input word
//   dir : DIR_LEFT rotates toward the MSB, DIR_RIGHT toward the LSB
//   q   : d rotated by one position, end bit wraps around
module rot1_32
   import shifter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] d,
   input  logic             dir,
   output logic [WIDTH-1:0] q
);

   always_comb begin
      if (dir == DIR_LEFT) q = {d[WIDTH-2:0], d[WIDTH-1]};
      else                 q = {d[0], d[WIDTH-1:1]};
   end

endmodule

// File: rtl/serial_unrotator_32.sv
// Multi-cycle inverse rotator: takes a word rotated by in_amt in direction
// in_lr and rotates it back one bit per clock, with valid/ready on both sides.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake (in_ready registered, high in IDLE)
//   in_data/in_amt/in_lr: rotated word, rotation amount, original direction
//   out_valid/out_ready : output handshake (out_valid high in DONE)
//   out_data/out_amt    : recovered word, echo of accepted amount
//   busy                : high in SHIFT or DONE
module serial_unrotator_32
   import shifter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int AMT_W = DEF_AMT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AMT_W-1:0] in_amt,
   input  logic             in_lr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [AMT_W-1:0] out_amt,
   output logic             busy
);

   state_t           state;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] rot_d;
   logic [AMT_W-1:0] cnt_q;
   logic [AMT_W-1:0] amt_q;
   logic             lr_q;

   rot1_32 #(.WIDTH(WIDTH)) u_rot (
      .d   (data_q),
      .dir (inverse_dir(lr_q)),
      .q   (rot_d)
   );

   // The data register doubles as the output; out_valid gates it.
   assign out_data = data_q;
   assign out_amt  = amt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         data_q    <= '0;
         amt_q     <= '0;
         cnt_q     <= '0;
         lr_q      <= DIR_RIGHT;
      end else begin
         case (state)
            ST_IDLE: begin
               // in_ready is low straight out of reset and comes up here.
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  data_q   <= in_data;
                  amt_q    <= in_amt;
                  cnt_q    <= in_amt;
                  lr_q     <= in_lr;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  if (in_amt == '0) begin
                     state     <= ST_DONE;
                     out_valid <= 1'b1;
                  end else begin
                     state <= ST_SHIFT;
                  end
               end
            end
            ST_SHIFT: begin
               data_q <= rot_d;
               cnt_q  <= cnt_q - 1'b1;
               // Last rotation happens on the same edge that enters DONE.
               if (cnt_q == AMT_W'(1)) begin
                  state     <= ST_DONE;
                  out_valid <= 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_unrotator_32.sv
module tb_serial_unrotator_32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [4:0]  in_amt;
   logic        in_lr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_amt;
   logic        busy;

   int checks = 0;
   int errors = 0;

   serial_unrotator_32 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_lr     (in_lr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_amt   (out_amt),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Reference: plain modular rotations on a doubled word.
   function automatic logic [31:0] rotl(input logic [31:0] d, input int n);
      logic [63:0] dd;
      dd = {d, d} << n;
      return dd[63:32];
   endfunction

   function automatic logic [31:0] rotr(input logic [31:0] d, input int n);
      logic [63:0] dd;
      dd = {d, d} >> n;
      return dd[31:0];
   endfunction

   // lr=0 means the word was rotated right, so the recovery rotates left.
   function automatic logic [31:0] unrot(input logic [31:0] d, input int n, input logic lr);
      return lr ? rotr(d, n) : rotl(d, n);
   endfunction

   // Present one word, then wait for out_valid. lat counts edges after the
   // accept edge until out_valid is seen (-1 on timeout).
   task automatic push_wait(input logic [31:0] d, input logic [4:0] a, input logic lr,
                            output int lat);
      int k;
      k = 0;
      while (!in_ready && k < 200) begin
         @(posedge clk); #1; k++;
      end
      in_data = d; in_amt = a; in_lr = lr; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1; lat++;
      end
      if (!out_valid) lat = -1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_lr = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b000 || out_data !== 32'h0 || out_amt !== 5'd0) begin
         errors++;
         $display("FAIL reset_vals: rdy/vld/busy=%b data=%h amt=%0d required 000/0/0",
                  {in_ready, out_valid, busy}, out_data, out_amt);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL reset_release_rdy: in_ready=%b required 0", in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_first_edge_rdy: in_ready=%b required 1", in_ready);
      end
   endtask

   task automatic test_directed;
      int lat;
      logic [31:0] dv [5] = '{32'hEF56DF77, 32'h81234567, 32'hBBCCDDAA, 32'hCAFEBABE, 32'h00000001};
      logic [4:0]  av [5] = '{5'd1, 5'd4, 5'd8, 5'd0, 5'd31};
      logic        lv [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [31:0] ev [5] = '{32'hDEADBEEF, 32'h12345678, 32'hAABBCCDD, 32'hCAFEBABE, 32'h80000000};
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         push_wait(dv[i], av[i], lv[i], lat);
         checks++;
         if (lat !== int'(av[i])) begin
            errors++; $display("FAIL dir_latency[%0d]: lat=%0d required %0d", i, lat, av[i]);
         end
         checks++;
         if (out_data !== ev[i] || out_amt !== av[i] || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL dir_out[%0d]: data=%h amt=%0d busy=%b rdy=%b required %h %0d 1 0",
                     i, out_data, out_amt, busy, in_ready, ev[i], av[i]);
         end
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL dir_release[%0d]: vld=%b busy=%b rdy=%b required 0 0 1",
                     i, out_valid, busy, in_ready);
         end
      end
   endtask

   task automatic test_backpressure;
      int lat;
      out_ready = 1'b0;
      push_wait(32'hB00CFACE, 5'd16, 1'b1, lat);
      checks++;
      if (lat !== 16) begin
         errors++; $display("FAIL bp_latency: lat=%0d required 16", lat);
      end
      // A competing word must be ignored while the result waits.
      in_valid = 1'b1; in_data = 32'h12345678; in_amt = 5'd3; in_lr = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_data !== 32'hFACEB00C || out_amt !== 5'd16 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: data=%h amt=%0d vld=%b rdy=%b required FACEB00C 16 1 0",
                     i, out_data, out_amt, out_valid, in_ready);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_transfer: vld=%b rdy=%b required 0 1", out_valid, in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL bp_single: vld=%b busy=%b required 0 0", out_valid, busy);
      end
   endtask

   // in_valid held high continuously: one accept every amt+2 edges.
   task automatic test_back_to_back;
      int edge_no, hs_cnt, xfer, last_hs;
      logic hs, xf;
      logic [31:0] orig;
      orig = 32'h0F1E2D3C;
      out_ready = 1'b1;
      in_data = rotr(orig, 3); in_amt = 5'd3; in_lr = 1'b0; in_valid = 1'b1;
      edge_no = 0; hs_cnt = 0; xfer = 0; last_hs = -1;
      while ((hs_cnt < 3 || xfer < 3) && edge_no < 100) begin
         hs = in_valid && in_ready;
         xf = out_valid && out_ready;
         if (xf) begin
            checks++;
            if (out_data !== orig) begin
               errors++; $display("FAIL b2b_data: data=%h required %h", out_data, orig);
            end
            xfer++;
         end
         @(posedge clk); #1;
         edge_no++;
         if (hs) begin
            if (last_hs >= 0) begin
               checks++;
               if (edge_no - last_hs !== 5) begin
                  errors++; $display("FAIL b2b_interval: %0d edges required 5", edge_no - last_hs);
               end
            end
            last_hs = edge_no;
            hs_cnt++;
            if (hs_cnt == 3) in_valid = 1'b0;
         end
      end
      checks++;
      if (hs_cnt !== 3 || xfer !== 3) begin
         errors++; $display("FAIL b2b_count: accepts=%0d transfers=%0d required 3 3", hs_cnt, xfer);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      int lat, k;
      out_ready = 1'b1;
      k = 0;
      while (!in_ready && k < 100) begin
         @(posedge clk); #1; k++;
      end
      in_data = 32'h13579BDF; in_amt = 5'd20; in_lr = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, busy, in_ready} !== 3'b000 || out_data !== 32'h0 || out_amt !== 5'd0) begin
         errors++;
         $display("FAIL midrst_clear: vld/busy/rdy=%b data=%h amt=%0d required 000 0 0",
                  {out_valid, busy, in_ready}, out_data, out_amt);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL midrst_release: rdy=%b vld=%b required 0 0", in_ready, out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL midrst_rdy: in_ready=%b required 1", in_ready);
      end
      push_wait(32'h2468ACE1, 5'd5, 1'b0, lat);
      checks++;
      if (lat !== 5 || out_data !== rotl(32'h2468ACE1, 5)) begin
         errors++;
         $display("FAIL midrst_next: lat=%0d data=%h required 5 %h", lat, out_data, rotl(32'h2468ACE1, 5));
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random;
      int lat, stall;
      logic [31:0] orig, rot;
      logic [4:0]  a;
      logic        lr;
      for (int i = 0; i < 40; i++) begin
         orig  = $urandom;
         a     = 5'($urandom_range(0, 31));
         lr    = 1'($urandom_range(0, 1));
         stall = $urandom_range(0, 3);
         // Apply the forward rotation the combinational shifter would have done.
         rot   = lr ? rotl(orig, a) : rotr(orig, a);
         out_ready = (stall == 0);
         push_wait(rot, a, lr, lat);
         checks++;
         if (lat !== int'(a) || out_data !== orig || out_data !== unrot(rot, a, lr) || out_amt !== a) begin
            errors++;
            $display("FAIL rand[%0d]: lat=%0d data=%h amt=%0d required %0d %h %0d",
                     i, lat, out_data, out_amt, a, orig, a);
         end
         repeat (stall) @(posedge clk);
         #1;
         checks++;
         if (out_valid !== 1'b1 || out_data !== orig) begin
            errors++;
            $display("FAIL rand_hold[%0d]: vld=%b data=%h required 1 %h", i, out_valid, out_data, orig);
         end
         out_ready = 1'b1;
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rand_release[%0d]: vld=%b rdy=%b required 0 1", i, out_valid, in_ready);
         end
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_backpressure;
      test_back_to_back;
      test_reset_mid;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
